// File: rtl/xif_offload_queue.sv
// CORE-V-XIF coprocessor front end: accepts one custom opcode, buffers it until
// commit, dispatches committed entries in order to one execution unit, returns results.
module xif_offload_queue #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned XLEN          = 32,
  parameter logic [6:0]  ACCEPT_OPCODE = 7'h0B
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [2*XLEN-1:0]   issue_rs_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [31:0]         ex_instr_o,
  output logic [2*XLEN-1:0]   ex_rs_o,
  input  logic                ex_done_i,
  input  logic [XLEN-1:0]     ex_data_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    E_FREE,
    E_PENDING,
    E_COMMITTED,
    E_KILLED
  } ent_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_RESP
  } fsm_state_e;

  ent_state_e          ent_state_q [DEPTH];
  ent_state_e          ent_state_d [DEPTH];
  logic [ID_WIDTH-1:0] ent_id_q    [DEPTH];
  logic [ID_WIDTH-1:0] ent_id_d    [DEPTH];
  logic [31:0]         ent_instr_q [DEPTH];
  logic [31:0]         ent_instr_d [DEPTH];
  logic [2*XLEN-1:0]   ent_rs_q    [DEPTH];
  logic [2*XLEN-1:0]   ent_rs_d    [DEPTH];

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  fsm_state_e          state_q, state_d;

  logic [ID_WIDTH-1:0] result_id_q, result_id_d;
  logic [XLEN-1:0]     result_data_q, result_data_d;
  logic [4:0]          result_rd_q, result_rd_d;
  logic                result_we_q, result_we_d;

  logic                push;
  logic                pop;
  logic                latch_result;
  ent_state_e          head_state;
  logic [31:0]         head_instr;

  assign issue_ready_o     = (count_q != CNT_W'(DEPTH));
  assign issue_accept_o    = (issue_instr_i[6:0] == ACCEPT_OPCODE) & (&issue_rs_valid_i);
  assign issue_writeback_o = issue_accept_o & (issue_instr_i[11:7] != 5'd0);
  assign push              = issue_valid_i & issue_ready_o & issue_accept_o;

  assign head_state = ent_state_q[head_q];
  assign head_instr = ent_instr_q[head_q];

  // Head FSM: one instruction in flight between dispatch and result handshake
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    latch_result = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head_state == E_KILLED) begin
            pop = 1'b1;
          end else if (head_state == E_COMMITTED) begin
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (ex_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ex_done_i) begin
          latch_result = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage: commit matching, push at tail, pop at head
  always_comb begin
    ent_state_d = ent_state_q;
    ent_id_d    = ent_id_q;
    ent_instr_d = ent_instr_q;
    ent_rs_d    = ent_rs_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && (ent_state_q[i] == E_PENDING) && (ent_id_q[i] == commit_id_i)) begin
        ent_state_d[i] = commit_kill_i ? E_KILLED : E_COMMITTED;
      end
    end

    if (pop) begin
      ent_state_d[head_q] = E_FREE;
      head_d              = head_q + PTR_W'(1);
    end

    // A pushed entry sees a same-cycle commit of its own id
    if (push) begin
      ent_id_d[tail_q]    = issue_id_i;
      ent_instr_d[tail_q] = issue_instr_i;
      ent_rs_d[tail_q]    = issue_rs_i;
      if (commit_valid_i && (commit_id_i == issue_id_i)) begin
        ent_state_d[tail_q] = commit_kill_i ? E_KILLED : E_COMMITTED;
      end else begin
        ent_state_d[tail_q] = E_PENDING;
      end
      tail_d = tail_q + PTR_W'(1);
    end
  end

  always_comb begin
    result_id_d   = result_id_q;
    result_data_d = result_data_q;
    result_rd_d   = result_rd_q;
    result_we_d   = result_we_q;
    if (latch_result) begin
      result_id_d   = ent_id_q[head_q];
      result_data_d = ex_data_i;
      result_rd_d   = head_instr[11:7];
      result_we_d   = (head_instr[11:7] != 5'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      result_id_q   <= '0;
      result_data_q <= '0;
      result_rd_q   <= '0;
      result_we_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_state_q[i] <= E_FREE;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      result_id_q   <= result_id_d;
      result_data_q <= result_data_d;
      result_rd_q   <= result_rd_d;
      result_we_q   <= result_we_d;
      ent_state_q   <= ent_state_d;
    end
  end

  // Payload is qualified by entry state, so it needs no reset
  always_ff @(posedge clk_i) begin
    ent_id_q    <= ent_id_d;
    ent_instr_q <= ent_instr_d;
    ent_rs_q    <= ent_rs_d;
  end

  assign ex_valid_o     = (state_q == S_DISPATCH);
  assign ex_instr_o     = ex_valid_o ? head_instr : 32'd0;
  assign ex_rs_o        = ex_valid_o ? ent_rs_q[head_q] : '0;
  assign result_valid_o = (state_q == S_RESP);
  assign result_id_o    = result_id_q;
  assign result_data_o  = result_data_q;
  assign result_rd_o    = result_rd_q;
  assign result_we_o    = result_we_q;

endmodule
